// File: rtl/tick_stretch_pkg.sv
// Shared definitions for the tick_stretch block: state encoding and default counter width.
package tick_stretch_pkg;

  localparam int unsigned WIDTH_DEF = 30;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter with a registered value and a "value is one" flag.
// Decrementing stops at zero.
module load_down_counter
  import tick_stretch_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEF
) (
  input  logic             rst_i,
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o,
  output logic             one_o
);

  localparam logic [Width-1:0] ZERO = {Width{1'b0}};
  localparam logic [Width-1:0] ONE  = {{(Width-1){1'b0}}, 1'b1};

  logic [Width-1:0] q_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_r <= ZERO;
    end else if (load_i) begin
      q_r <= d_i;
    end else if (en_i && (q_r != ZERO)) begin
      q_r <= q_r - ONE;
    end else begin
      q_r <= q_r;
    end
  end

  assign q_o   = q_r;
  assign one_o = (q_r == ONE);

endmodule

// File: rtl/tick_stretch.sv
// Stretches a start tick into a level of k_i cycles followed by a one-cycle done tick.
// Define TICK_STRETCH_RETRIG_EN to let a start during the hold reload the count.
module tick_stretch
  import tick_stretch_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEF
) (
  input  logic             rst_i,
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [Width-1:0] k_i,
  output logic             level_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam logic [Width-1:0] ZERO = {Width{1'b0}};

  state_e           state_r;
  logic             level_r;
  logic             done_r;
  logic             busy_r;
  logic             retrig_s;
  logic             load_s;
  logic             en_s;
  logic             k_zero_s;
  logic [Width-1:0] cnt_q_s;
  logic             cnt_one_s;

  assign k_zero_s = (k_i == ZERO);

  // Counter control: load on an accepted start or retrigger, otherwise count down while holding.
  always_comb begin
    retrig_s = 1'b0;
    load_s   = 1'b0;
    en_s     = 1'b0;
    if (state_r == S_IDLE) begin
      load_s = start_i && !k_zero_s;
    end else if (state_r == S_HOLD) begin
`ifdef TICK_STRETCH_RETRIG_EN
      retrig_s = start_i;
`else
      retrig_s = 1'b0;
`endif
      load_s = retrig_s && !k_zero_s;
      en_s   = !load_s && (cnt_q_s != ZERO);
    end else begin
      load_s = 1'b0;
      en_s   = 1'b0;
    end
  end

  load_down_counter #(.Width(Width)) u_cnt (
    .rst_i (rst_i),
    .clk_i (clk_i),
    .load_i(load_s),
    .en_i  (en_s),
    .d_i   (k_i),
    .q_o   (cnt_q_s),
    .one_o (cnt_one_s)
  );

  // FSM with outputs registered alongside the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
      level_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i && !k_zero_s) begin
            state_r <= S_HOLD;
            level_r <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
          end else if (start_i) begin
            state_r <= S_DONE;
            level_r <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
            level_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        S_HOLD: begin
          // A retrigger with a nonzero length outranks the terminal count.
          if ((retrig_s && k_zero_s) || (!retrig_s && cnt_one_s)) begin
            state_r <= S_DONE;
            level_r <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_HOLD;
            level_r <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          level_r <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          level_r <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign level_o = level_r;
  assign done_o  = done_r;
  assign busy_o  = busy_r;

endmodule

// File: doc/tick_stretch.md
# tick_stretch

Converts a single-cycle start tick into a level held high for a programmable number of clock cycles, then emits a one-cycle completion tick. It is the tick-to-level counterpart of the button-to-tick path: it consumes `start_o`-style pulses and drives LEDs, enables or gate windows that must stay asserted for up to 10 s at the board clock.

## Interface
- `Width`, 30, counter width; bounds the hold length `k_i`.
- `rst_i`  input  1  synchronous, active-high reset.
- `clk_i`  input  1  single system clock; all logic on its rising edge.
- `start_i`  input  1  single-cycle request tick.
- `k_i`  input  Width  hold length in clock cycles, sampled only when a start is accepted.
- `level_o`  output  1  stretched level, registered.
- `done_o`  output  1  one-cycle completion tick, registered.
- `busy_o`  output  1  high in any state other than IDLE, registered.

## Operation
- FSM states:
  - IDLE: all outputs low.
  - HOLD: `level_o`=1, `busy_o`=1.
  - DONE: `done_o`=1, `busy_o`=1, `level_o`=0.
- IDLE with `start_i`=1:
  - `k_i`≠0: `cnt <= k_i`, go to HOLD.
  - `k_i`=0: go directly to DONE. No level cycle is produced.
- HOLD: `cnt` decrements by 1 each cycle.
  - When `cnt`==1, the next state is DONE.
  - `cnt` never wraps below 0.
- DONE lasts exactly one cycle, then returns to IDLE unconditionally.
  - `start_i` is ignored in DONE in all configurations.
- `k_i` changes are ignored while outside IDLE. The latched value governs, except on a retrigger (see Configuration).
- Reset, including mid-HOLD or mid-DONE:
  - Next state is IDLE, `cnt`=0, `level_o`=0, `done_o`=0, `busy_o`=0.
  - No `done_o` is emitted for an aborted hold.
- `rst_i` and `start_i` asserted in the same cycle: reset wins and the start is lost.

## Timing
- Start accepted at edge n with `k_i`=K≥1:
  - `level_o` is high for cycles n+1 … n+K, exactly K cycles.
  - `done_o` is high in cycle n+K+1.
  - IDLE is reached at n+K+1, after `done_o`.
- Start accepted at edge n with `k_i`=0: `done_o` is high in cycle n+1 and `level_o` stays low.
- Earliest next accepted start: the cycle after `done_o` falls, i.e. edge n+K+2.
- Maximum hold: 2^Width−1 cycles. This is ≈10.7 s at 100 MHz for `Width`=30.
- All outputs come from registers. No combinational path exists from `start_i` to any output.

## Configuration
- Macro: `TICK_STRETCH_RETRIG_EN`.
- Defined: `start_i` in HOLD retriggers the hold.
  - `k_i`≠0: `cnt <= k_i`. `level_o` stays high for exactly `k_i` more cycles counted from the retrigger edge, with no glitch.
  - `k_i`=0: go to DONE on the next edge.
- Undefined: `start_i` in HOLD is ignored and the hold completes with the original count.

## Structure
- Shared package `tick_stretch_pkg`:
  - State encoding localparams `ST_IDLE`=2'd0, `ST_HOLD`=2'd1, `ST_DONE`=2'd2.
  - Default `Width`=30.
- Sub-module `load_down_counter`, parameterised by `Width`:
  - Inputs: `rst_i`, `clk_i`, `load_i`, `en_i`, `d_i`.
  - Outputs: `q_o` and a `one_o` flag (`q_o`==1).
- The top level holds the FSM and the output registers.

## Test plan
- `k_i`=5, start at cycle 10 → `level_o` high in cycles 11–15, `done_o` high in cycle 16, `busy_o` high in cycles 11–16.
- `k_i`=0, start → `done_o` high for one cycle right after the start, `level_o` never high.
- `k_i` changed from 5 to 2 at cycle 12 during the hold from the first scenario → timing identical to the first scenario.
- Hold with `k_i`=8, second start at the 3rd HOLD cycle with `k_i`=4:
  - Macro undefined → `level_o` high for 8 cycles.
  - Macro defined → `level_o` high for 3+4=7 cycles, then `done_o`.
- `rst_i` pulsed at the 4th cycle of a `k_i`=10 hold → all outputs 0 the next cycle, no `done_o`, and a start one cycle after reset is accepted normally.
- `start_i` asserted in the DONE cycle → ignored, IDLE follows, and no new hold begins.
